// File: rtl/vga_sync_generator_if.sv
// Raster timing bundle from the VGA sync generator to the pixel fetch stage.
// The generator drives it through the master modport; consumers use slave.
interface vga_sync_generator_if;
  logic       hsync;
  logic       vsync;
  logic [9:0] x;
  logic [9:0] y;
  logic       visible;
  logic       line_start;
  logic       frame_start;
  logic [6:0] col;
  logic [4:0] row;
  logic [2:0] glyph_x;
  logic [3:0] glyph_y;
  logic       blink;

  modport master (
    output hsync, vsync, x, y, visible, line_start, frame_start,
           col, row, glyph_x, glyph_y, blink
  );

  modport slave (
    input  hsync, vsync, x, y, visible, line_start, frame_start,
           col, row, glyph_x, glyph_y, blink
  );
endinterface

// File: rtl/vga_sync_generator.sv
// Free-running VGA raster timing generator. All outputs are registered from
// the next-state counters so sync, strobes and coordinates share one pixel.
module vga_sync_generator #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter bit HSYNC_POL    = 1'b0,
  parameter bit VSYNC_POL    = 1'b0,
  parameter int CHAR_W       = 8,
  parameter int CHAR_H       = 16,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                 clk,
  input  logic                 reset,
  vga_sync_generator_if.master vga
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CW_BITS  = $clog2(CHAR_W);
  localparam int CH_BITS  = $clog2(CHAR_H);
  localparam int BW       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS     = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS     = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] X_MASK    = 10'(CHAR_W - 1);
  localparam logic [9:0] Y_MASK    = 10'(CHAR_H - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  // Reset parks the raster on the last blank pixel; fields follow x/y.
  localparam logic [6:0] COL_RST = 7'(H_LAST >> CW_BITS);
  localparam logic [4:0] ROW_RST = 5'(V_LAST >> CH_BITS);
  localparam logic [2:0] GX_RST  = 3'(H_LAST & X_MASK);
  localparam logic [3:0] GY_RST  = 4'(V_LAST & Y_MASK);

  logic [9:0]    x_q, y_q;
  logic [9:0]    x_next, y_next;
  logic          hsync_q, vsync_q, visible_q;
  logic          line_start_q, frame_start_q;
  logic [6:0]    col_q;
  logic [4:0]    row_q;
  logic [2:0]    glyph_x_q;
  logic [3:0]    glyph_y_q;
  logic          blink_q;
  logic [BW-1:0] blink_cnt;
  logic          hs_on, vs_on, vis_next, ls_next, fs_next;

  always_comb begin
    x_next = (x_q == H_LAST) ? 10'd0 : x_q + 10'd1;
    y_next = y_q;
    if (x_q == H_LAST) begin
      y_next = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
    end
    hs_on    = (x_next >= HS_START) && (x_next < HS_END);
    vs_on    = (y_next >= VS_START) && (y_next < VS_END);
    vis_next = (x_next < H_VIS) && (y_next < V_VIS);
    ls_next  = (x_next == 10'd0);
    fs_next  = (x_next == 10'd0) && (y_next == 10'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      visible_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      col_q         <= COL_RST;
      row_q         <= ROW_RST;
      glyph_x_q     <= GX_RST;
      glyph_y_q     <= GY_RST;
      blink_q       <= 1'b0;
      blink_cnt     <= '0;
    end else begin
      x_q           <= x_next;
      y_q           <= y_next;
      hsync_q       <= hs_on ? HSYNC_POL : ~HSYNC_POL;
      vsync_q       <= vs_on ? VSYNC_POL : ~VSYNC_POL;
      visible_q     <= vis_next;
      line_start_q  <= ls_next;
      frame_start_q <= fs_next;
      col_q         <= 7'(x_next >> CW_BITS);
      row_q         <= 5'(y_next >> CH_BITS);
      glyph_x_q     <= 3'(x_next & X_MASK);
      glyph_y_q     <= 4'(y_next & Y_MASK);
      // Blink advances on the same edge that raises frame_start.
      if (fs_next) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink_q   <= ~blink_q;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.visible     = visible_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
  assign vga.col         = col_q;
  assign vga.row         = row_q;
  assign vga.glyph_x     = glyph_x_q;
  assign vga.glyph_y     = glyph_y_q;
  assign vga.blink       = blink_q;

endmodule
